// File: rtl/cp0_exc_ctrl.sv
// CP0 system register file with a nested status-mask stack and a level-sensitive interrupt controller.
// Define CP0_TIMER_EN to turn regs 9/11 into a Count/Compare timer driving Cause[15].
module cp0_exc_ctrl #(
  parameter int          NUM_IRQ     = 5,
  parameter int          STACK_DEPTH = 3,
  parameter int          SHIFT       = 5,
  parameter logic [31:0] STATUS_INIT = 32'h0000_001F
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               mfc0_i,
  input  logic               mtc0_i,
  input  logic               exc_req_i,
  input  logic [4:0]         exc_code_i,
  input  logic               eret_i,
  input  logic [4:0]         raddr_i,
  input  logic [4:0]         waddr_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        pc_i,
  input  logic [NUM_IRQ-1:0] irq_in_i,
  output logic [31:0]        rdata_o,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic               irq_take_o,
  output logic               nest_ovf_o
);

  localparam int              FW        = SHIFT * STACK_DEPTH;
  localparam int              DW        = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]   DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [31:0]     FMASK     = 32'((64'd1 << FW) - 64'd1);

  logic [31:0]          rf_q [32];
  logic [NUM_IRQ-1:0]   irq_sync1_q, irq_sync2_q;
  logic [1:0]           sw_ip_q;
  logic [4:0]           exc_code_q;
  logic [DW-1:0]        depth_q;
  logic                 irq_take_q;
  logic                 nest_ovf_q;
`ifdef CP0_TIMER_EN
  logic                 timer_ip_q;
`endif

  logic [31:0]          status_q;
  logic [31:0]          cause_d;
  logic [FW-1:0]        field_q, field_push_d, field_pop_d;
  logic [31:0]          status_push_d, status_pop_d;
  logic [STACK_DEPTH-1:0] level_nz;
  logic [DW-1:0]        depth_wr_d;
  logic                 pend;
  logic                 entry_d;
  logic [4:0]           entry_code_d;

  assign status_q      = rf_q[12];
  assign field_q       = status_q[FW-1:0];
  assign field_push_d  = field_q << SHIFT;
  assign field_pop_d   = field_q >> SHIFT;
  assign status_push_d = (status_q & ~FMASK) | 32'(field_push_d);
  assign status_pop_d  = (status_q & ~FMASK) | 32'(field_pop_d);

  // A Status write re-derives nesting depth from how many stack levels are nonzero.
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_lvl
    assign level_nz[gi] = |wdata_i[gi*SHIFT +: SHIFT];
  end

  always_comb begin
    depth_wr_d = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      depth_wr_d = depth_wr_d + DW'(level_nz[k]);
    end
  end

  always_comb begin
    cause_d                  = '0;
    cause_d[10 +: NUM_IRQ]   = irq_sync2_q;
    cause_d[9:8]             = sw_ip_q;
    cause_d[6:2]             = exc_code_q;
`ifdef CP0_TIMER_EN
    cause_d[15]              = timer_ip_q;
`endif
  end

  assign pend         = (|(cause_d[15:8] & status_q[15:8])) & status_q[0];
  assign entry_d      = exc_req_i | (pend & ~eret_i);
  assign entry_code_d = exc_req_i ? exc_code_i : 5'd0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 32; k++) begin
        rf_q[k] <= '0;
      end
      rf_q[12]    <= STATUS_INIT;
      irq_sync1_q <= '0;
      irq_sync2_q <= '0;
      sw_ip_q     <= '0;
      exc_code_q  <= '0;
      depth_q     <= '0;
      irq_take_q  <= 1'b0;
      nest_ovf_q  <= 1'b0;
`ifdef CP0_TIMER_EN
      timer_ip_q  <= 1'b0;
`endif
    end else begin
      irq_sync1_q <= irq_in_i;
      irq_sync2_q <= irq_sync1_q;
      irq_take_q  <= 1'b0;
`ifdef CP0_TIMER_EN
      rf_q[9] <= rf_q[9] + 32'd1;
      if (rf_q[9] + 32'd1 == rf_q[11]) timer_ip_q <= 1'b1;
`endif
      if (mtc0_i) begin
        case (waddr_i)
          5'd12: begin
            rf_q[12]   <= wdata_i;
            depth_q    <= depth_wr_d;
            nest_ovf_q <= 1'b0;
          end
          5'd13: sw_ip_q <= wdata_i[9:8];
`ifdef CP0_TIMER_EN
          5'd11: begin
            rf_q[11]   <= wdata_i;
            timer_ip_q <= 1'b0;
          end
`endif
          default: rf_q[waddr_i] <= wdata_i;
        endcase
      end else if (entry_d) begin
        rf_q[14]   <= pc_i;
        exc_code_q <= entry_code_d;
        rf_q[12]   <= status_push_d;
        if (depth_q == DEPTH_MAX) nest_ovf_q <= 1'b1;
        else                      depth_q    <= depth_q + DW'(1);
        irq_take_q <= ~exc_req_i;
      end else if (eret_i) begin
        rf_q[12] <= status_pop_d;
        if (depth_q != '0) depth_q <= depth_q - DW'(1);
      end
    end
  end

  assign rdata_o    = !mfc0_i ? 32'h0 : ((raddr_i == 5'd13) ? cause_d : rf_q[raddr_i]);
  assign status_o   = status_q;
  assign cause_o    = cause_d;
  assign epc_o      = rf_q[14];
  assign irq_take_o = irq_take_q;
  assign nest_ovf_o = nest_ovf_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
// Timer checks are compiled only when CP0_TIMER_EN is defined.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mfc0, mtc0, exc_req, eret;
  logic [4:0]  exc_code, raddr, waddr;
  logic [31:0] wdata, pc;
  logic [4:0]  irq_in;
  logic [31:0] rdata, status, cause, epc;
  logic        irq_take, nest_ovf;

  cp0_exc_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .mfc0_i     (mfc0),
    .mtc0_i     (mtc0),
    .exc_req_i  (exc_req),
    .exc_code_i (exc_code),
    .eret_i     (eret),
    .raddr_i    (raddr),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .pc_i       (pc),
    .irq_in_i   (irq_in),
    .rdata_o    (rdata),
    .status_o   (status),
    .cause_o    (cause),
    .epc_o      (epc),
    .irq_take_o (irq_take),
    .nest_ovf_o (nest_ovf)
  );

  always #5 clk = ~clk;

  localparam int S_STATUS = 0, S_CAUSE = 1, S_EPC = 2, S_OVF = 3, S_RDATA = 4, S_TAKE = 5, S_C15 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] irq_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  chk_t        mc;
  logic [31:0] mact;
  logic [31:0] mexp;

  // Monitor: drains queued expectations each cycle and matches every irq_take pulse.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      case (mc.sel)
        S_STATUS: mact = status;
        S_CAUSE:  mact = cause;
        S_EPC:    mact = epc;
        S_OVF:    mact = {31'b0, nest_ovf};
        S_RDATA:  mact = rdata;
        S_TAKE:   mact = {31'b0, irq_take};
        default:  mact = {31'b0, cause[15]};
      endcase
      n_chk++;
      if (mact !== mc.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mc.name, mact, mc.exp);
      end else begin
        $display("ok   %s = %h", mc.name, mact);
      end
    end
    if (irq_take === 1'b1) begin
      n_chk++;
      if (irq_q.size() == 0) begin
        n_fail++;
        $display("FAIL irq_take: got unexpected pulse, epc %h, required no pulse", epc);
      end else begin
        mexp = irq_q.pop_front();
        if (epc !== mexp || cause[6:2] !== 5'd0) begin
          n_fail++;
          $display("FAIL irq_entry: got epc %h code %0d expected epc %h code 0", epc, cause[6:2], mexp);
        end else begin
          $display("ok   irq_entry epc = %h", epc);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mfc0 = 1'b0; mtc0 = 1'b0; exc_req = 1'b0; eret = 1'b0;
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; waddr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] p);
    exc_req = 1'b1; exc_code = code; pc = p;
    tick();
    idle();
  endtask

  logic [31:0] st4 [4] = '{32'h3E0, 32'h7C00, 32'h0, 32'h0};
  logic [31:0] st3 [3] = '{32'h3E0, 32'h7C00, 32'h0};

  initial begin
    rst_n = 1'b0; idle();
    exc_code = '0; raddr = '0; waddr = '0; wdata = '0; pc = '0; irq_in = '0;
    #1;
    expect_val("rst_status", S_STATUS, 32'h1F);
    expect_val("rst_cause",  S_CAUSE,  32'h0);
    expect_val("rst_epc",    S_EPC,    32'h0);
    expect_val("rst_ovf",    S_OVF,    32'h0);
    expect_val("rst_take",   S_TAKE,   32'h0);
    expect_val("rst_rdata",  S_RDATA,  32'h0);
    #11 rst_n = 1'b1;
    tick();

    // Single exception entry and return
    do_exc(5'd8, 32'h0040_0010);
    expect_val("exc_epc",    S_EPC,    32'h0040_0010);
    expect_val("exc_cause",  S_CAUSE,  32'h20);
    expect_val("exc_status", S_STATUS, 32'h3E0);
    mfc0 = 1'b1; raddr = 5'd14;
    expect_val("mfc0_epc", S_RDATA, 32'h0040_0010);
    tick(); idle();
    eret = 1'b1;
    tick(); idle();
    expect_val("eret_status", S_STATUS, 32'h1F);
    expect_val("eret_cause",  S_CAUSE,  32'h20);
    raddr = 5'd14;
    expect_val("rdata_no_mfc0", S_RDATA, 32'h0);
    tick();

    // Same-cycle read of a write target returns the old value
    mtc0 = 1'b1; waddr = 5'd14; wdata = 32'h1234_5678; mfc0 = 1'b1; raddr = 5'd14;
    expect_val("mfc0_old", S_RDATA, 32'h0040_0010);
    tick(); idle();
    expect_val("mtc0_epc", S_EPC, 32'h1234_5678);
    mfc0 = 1'b1; raddr = 5'd13;
    expect_val("mfc0_cause", S_RDATA, 32'h20);
    tick(); idle();
    do_mtc0(5'd13, 32'hFFFF_FFFF);
    expect_val("cause_wmask", S_CAUSE, 32'h320);
    do_mtc0(5'd13, 32'h0);
    expect_val("cause_clr", S_CAUSE, 32'h20);

    // Nesting overflow and depth recomputed from a Status write
    for (int k = 0; k < 4; k++) begin
      do_exc(5'd9, 32'h0040_0020 + 32'(4 * k));
      expect_val($sformatf("nest%0d_status", k), S_STATUS, st4[k]);
      expect_val($sformatf("nest%0d_ovf", k), S_OVF, (k == 3) ? 32'h1 : 32'h0);
    end
    do_mtc0(5'd12, 32'h1F);
    expect_val("wr12_ovf",    S_OVF,    32'h0);
    expect_val("wr12_status", S_STATUS, 32'h1F);
    for (int k = 0; k < 3; k++) begin
      do_exc(5'd9, 32'h0040_0040);
      expect_val($sformatf("redepth%0d_status", k), S_STATUS, st3[k]);
      expect_val($sformatf("redepth%0d_ovf", k), S_OVF, (k == 2) ? 32'h1 : 32'h0);
    end
    do_mtc0(5'd12, 32'h3E0);
    eret = 1'b1; tick(); idle();
    expect_val("pop_status", S_STATUS, 32'h1F);
    eret = 1'b1; tick(); idle();
    expect_val("pop_floor_status", S_STATUS, 32'h0);

    // Hardware interrupt: two sync flops, then accepted on the third edge
    do_mtc0(5'd12, 32'h401);
    pc = 32'h0040_0100;
    irq_in = 5'b00001;
    irq_q.push_back(32'h0040_0100);
    tick();
    expect_val("irq_p1_take", S_TAKE, 32'h0);
    expect_val("irq_p1_cause", S_CAUSE, 32'h24);
    tick();
    expect_val("irq_p2_take", S_TAKE, 32'h0);
    expect_val("irq_p2_cause", S_CAUSE, 32'h424);
    tick();
    expect_val("irq_p3_take", S_TAKE, 32'h1);
    expect_val("irq_p3_cause", S_CAUSE, 32'h400);
    expect_val("irq_p3_status", S_STATUS, 32'h20);
    tick();
    expect_val("irq_p4_take", S_TAKE, 32'h0);
    irq_in = '0;
    tick(); tick();
    expect_val("irq_drop_cause", S_CAUSE, 32'h0);

    // Interrupts masked by IE=0
    do_mtc0(5'd12, 32'h400);
    irq_in = 5'b00001;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_val($sformatf("ie0_take%0d", k), S_TAKE, 32'h0);
    end
    expect_val("ie0_cause", S_CAUSE, 32'h400);
    irq_in = '0;
    tick(); tick(); tick();

    // mtc0 beats exc_req and a pending interrupt; interrupt follows next edge
    do_mtc0(5'd12, 32'h401);
    pc = 32'h0040_0200;
    irq_in = 5'b00001;
    tick(); tick();
    mtc0 = 1'b1; waddr = 5'd30; wdata = 32'h0000_CAFE;
    exc_req = 1'b1; exc_code = 5'd12;
    irq_q.push_back(32'h0040_0200);
    tick(); idle();
    expect_val("prio_take0",  S_TAKE,   32'h0);
    expect_val("prio_status", S_STATUS, 32'h401);
    expect_val("prio_epc",    S_EPC,    32'h0040_0100);
    expect_val("prio_cause",  S_CAUSE,  32'h400);
    tick();
    expect_val("prio_take1",    S_TAKE,   32'h1);
    expect_val("prio_status_i", S_STATUS, 32'h20);
    expect_val("prio_epc_i",    S_EPC,    32'h0040_0200);
    mfc0 = 1'b1; raddr = 5'd30;
    expect_val("prio_wr30", S_RDATA, 32'h0000_CAFE);
    tick(); idle();
    irq_in = '0;
    tick(); tick();

`ifdef CP0_TIMER_EN
    do_mtc0(5'd11, 32'd10);
    do_mtc0(5'd9, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      expect_val($sformatf("timer_c15_%0d", k), S_C15, (k == 10) ? 32'h1 : 32'h0);
    end
    pc = 32'h0040_0400;
    irq_q.push_back(32'h0040_0400);
    do_mtc0(5'd12, 32'h8001);
    tick(); tick();
    do_mtc0(5'd11, 32'h0);
    expect_val("timer_clr", S_C15, 32'h0);
`else
    do_mtc0(5'd9, 32'h55);
    tick();
    mfc0 = 1'b1; raddr = 5'd9;
    expect_val("plain_reg9", S_RDATA, 32'h55);
    expect_val("plain_c15", S_C15, 32'h0);
    tick(); idle();
`endif

    // Asynchronous reset mid-run with nest_ovf set
    do_mtc0(5'd12, 32'h7FFF);
    do_exc(5'd4, 32'h0040_0300);
    do_exc(5'd4, 32'h0040_0304);
    do_exc(5'd4, 32'h0040_0308);
    do_exc(5'd4, 32'h0040_030C);
    expect_val("pre_rst_ovf", S_OVF, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    expect_val("arst_status", S_STATUS, 32'h1F);
    expect_val("arst_cause",  S_CAUSE,  32'h0);
    expect_val("arst_epc",    S_EPC,    32'h0);
    expect_val("arst_ovf",    S_OVF,    32'h0);
    #4 rst_n = 1'b1;
    tick(); tick();

    n_chk++;
    if (irq_q.size() != 0) begin
      n_fail++;
      $display("FAIL irq_missing: got %0d unmatched expected pulses, required 0", irq_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
